// File: rtl/mux_bist_diag_if.sv
// Bundle of the BIST control, result and mux-under-test signals.
interface mux_bist_diag_if #(
    parameter int unsigned SEL_W = 1,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned N = 1 << SEL_W;
    localparam int unsigned V = SEL_W + N;

    logic             start;
    logic             abort;
    logic [N-1:0]     dut_data;
    logic [SEL_W-1:0] dut_sel;
    logic             dut_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] fail_count;
    logic             first_fail_vld;
    logic [V-1:0]     first_fail_vec;
    logic [N-1:0]     suspect_mask;
    logic [1:0]       fault_class;

    // BIST controller side
    modport master (
        input  start, abort, dut_out,
        output dut_data, dut_sel, busy, done, fail_count,
               first_fail_vld, first_fail_vec, suspect_mask, fault_class
    );

    // Environment side: run control, mux under test and result consumer
    modport slave (
        output start, abort, dut_out,
        input  dut_data, dut_sel, busy, done, fail_count,
               first_fail_vld, first_fail_vec, suspect_mask, fault_class
    );
endinterface

// File: rtl/mux_bist_diag.sv
// Exhaustive self-test and fault localisation for a 2^SEL_W:1 single-bit mux.
module mux_bist_diag #(
    parameter int unsigned SEL_W  = 1,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    mux_bist_diag_if.master bus
);
    localparam int unsigned N     = 1 << SEL_W;
    localparam int unsigned V     = SEL_W + N;
    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [V-1:0]     vec;
    logic [SET_W-1:0] settle_cnt;
    logic             s0;
    logic             s1;

    logic             golden;
    logic             sample_fail;
    logic [CNT_W-1:0] nxt_count;
    logic [N-1:0]     nxt_mask;
    logic             nxt_s0;
    logic             nxt_s1;
    logic             mask_onehot;
    logic [1:0]       nxt_class;

    // Golden compare of the current vector and the result updates it would cause
    always_comb begin
        golden      = bus.dut_data[bus.dut_sel];
        sample_fail = (state == SAMPLE) && (bus.dut_out != golden);
        nxt_count   = bus.fail_count;
        nxt_mask    = bus.suspect_mask;
        nxt_s0      = s0;
        nxt_s1      = s1;
        if (sample_fail) begin
            if (bus.fail_count != {CNT_W{1'b1}}) begin
                nxt_count = bus.fail_count + CNT_W'(1);
            end
            nxt_mask = bus.suspect_mask & (N'(1) << bus.dut_sel);
            nxt_s0   = s0 | golden;
            nxt_s1   = s1 | ~golden;
        end
        mask_onehot = (nxt_mask != '0) && ((nxt_mask & (nxt_mask - N'(1))) == '0);
        if (nxt_count == '0) begin
            nxt_class = 2'b00;
        end else if (mask_onehot && nxt_s0 && !nxt_s1) begin
            nxt_class = 2'b01;
        end else if (mask_onehot && nxt_s1 && !nxt_s0) begin
            nxt_class = 2'b10;
        end else begin
            nxt_class = 2'b11;
        end
    end

    // Run sequencing, vector drive and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            vec                <= '0;
            settle_cnt         <= '0;
            s0                 <= 1'b0;
            s1                 <= 1'b0;
            bus.dut_data       <= '0;
            bus.dut_sel        <= '0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.fail_count     <= '0;
            bus.first_fail_vld <= 1'b0;
            bus.first_fail_vec <= '0;
            bus.suspect_mask   <= '1;
            bus.fault_class    <= 2'b00;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state              <= APPLY;
                        vec                <= '0;
                        settle_cnt         <= '0;
                        s0                 <= 1'b0;
                        s1                 <= 1'b0;
                        bus.dut_data       <= '0;
                        bus.dut_sel        <= '0;
                        bus.busy           <= 1'b1;
                        bus.done           <= 1'b0;
                        bus.fail_count     <= '0;
                        bus.first_fail_vld <= 1'b0;
                        bus.first_fail_vec <= '0;
                        bus.suspect_mask   <= '1;
                        bus.fault_class    <= 2'b00;
                    end
                end
                APPLY: begin
                    if (bus.abort) begin
                        state      <= IDLE;
                        settle_cnt <= '0;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b0;
                    end else if (settle_cnt == SET_W'(SETTLE - 1)) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                SAMPLE: begin
                    if (bus.abort) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b0;
                    end else begin
                        bus.fail_count   <= nxt_count;
                        bus.suspect_mask <= nxt_mask;
                        s0               <= nxt_s0;
                        s1               <= nxt_s1;
                        if (sample_fail && !bus.first_fail_vld) begin
                            bus.first_fail_vld <= 1'b1;
                            bus.first_fail_vec <= vec;
                        end
                        if (vec == {V{1'b1}}) begin
                            state           <= DONE;
                            bus.busy        <= 1'b0;
                            bus.done        <= 1'b1;
                            bus.fault_class <= nxt_class;
                        end else begin
                            state                        <= APPLY;
                            vec                          <= vec + V'(1);
                            {bus.dut_sel, bus.dut_data}  <= vec + V'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_bist_diag.sv
// Bench for mux_bist_diag: two configurations, a faultable mux model and a run-level reference.
module tb_mux_bist_diag;
    localparam int IDLE_M = 0;
    localparam int RUN_M  = 1;
    localparam int DONE_M = 2;

    // fault kinds of the mux model
    localparam int F_NONE = 0;
    localparam int F_SA0  = 1;
    localparam int F_SA1  = 2;
    localparam int F_SEL0 = 3;

    typedef struct packed {
        logic [31:0] cnt;
        logic        vld;
        logic [31:0] fvec;
        logic [31:0] mask;
        logic [1:0]  cls;
    } sum_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st[2]  = '{1'b0, 1'b0};
    logic ab[2]  = '{1'b0, 1'b0};
    int   flt[2] = '{0, 0};
    int   fk[2]  = '{0, 0};
    int   sw[2]  = '{1, 2};
    int   stl[2] = '{1, 2};

    int   n_vec = 0;
    int   n_err = 0;
    logic chk_en = 1'b0;

    int   m_run[2] = '{0, 0};
    int   m_j[2]   = '{0, 0};
    int   m_ns[2]  = '{0, 0};
    int   m_f[2]   = '{0, 0};
    int   m_k[2]   = '{0, 0};

    always #5 clk = ~clk;

    mux_bist_diag_if #(.SEL_W(1), .CNT_W(16)) bus_a ();
    mux_bist_diag_if #(.SEL_W(2), .CNT_W(16)) bus_b ();

    mux_bist_diag #(.SEL_W(1), .SETTLE(1), .CNT_W(16)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    mux_bist_diag #(.SEL_W(2), .SETTLE(2), .CNT_W(16)) u_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Mux under test with an injectable fault
    function automatic logic mux_eval(input int f, input int k, input logic [7:0] d, input logic [2:0] s);
        logic [7:0] dd;
        dd = d;
        if (f == F_SA0) dd[k] = 1'b0;
        if (f == F_SA1) dd[k] = 1'b1;
        if (f == F_SEL0) return dd[0];
        return dd[s];
    endfunction

    assign bus_a.start   = st[0];
    assign bus_a.abort   = ab[0];
    assign bus_b.start   = st[1];
    assign bus_b.abort   = ab[1];
    assign bus_a.dut_out = mux_eval(flt[0], fk[0], 8'(bus_a.dut_data), 3'(bus_a.dut_sel));
    assign bus_b.dut_out = mux_eval(flt[1], fk[1], 8'(bus_b.dut_data), 3'(bus_b.dut_sel));

    logic [31:0] o_vec[2];
    logic [31:0] o_fc[2];
    logic [31:0] o_fv[2];
    logic [31:0] o_mask[2];
    logic        o_busy[2];
    logic        o_done[2];
    logic        o_vld[2];
    logic [1:0]  o_cls[2];

    assign o_vec[0]  = 32'({bus_a.dut_sel, bus_a.dut_data});
    assign o_fc[0]   = 32'(bus_a.fail_count);
    assign o_fv[0]   = 32'(bus_a.first_fail_vec);
    assign o_mask[0] = 32'(bus_a.suspect_mask);
    assign o_busy[0] = bus_a.busy;
    assign o_done[0] = bus_a.done;
    assign o_vld[0]  = bus_a.first_fail_vld;
    assign o_cls[0]  = bus_a.fault_class;
    assign o_vec[1]  = 32'({bus_b.dut_sel, bus_b.dut_data});
    assign o_fc[1]   = 32'(bus_b.fail_count);
    assign o_fv[1]   = 32'(bus_b.first_fail_vec);
    assign o_mask[1] = 32'(bus_b.suspect_mask);
    assign o_busy[1] = bus_b.busy;
    assign o_done[1] = bus_b.done;
    assign o_vld[1]  = bus_b.first_fail_vld;
    assign o_cls[1]  = bus_b.fault_class;

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL inst%0d %s: got %0h expected %0h at %0t", inst, name, act, exp, $time);
        end
    endtask

    // Results expected after the first n vectors of a run have been judged
    function automatic sum_t summarize(input int s_w, input int f, input int k, input int n);
        sum_t r;
        int   nin;
        logic s0;
        logic s1;
        logic [7:0] d;
        logic [2:0] s;
        logic g;
        nin    = 1 << s_w;
        r.cnt  = 0;
        r.vld  = 1'b0;
        r.fvec = 0;
        r.mask = 32'((1 << nin) - 1);
        s0 = 1'b0;
        s1 = 1'b0;
        for (int v = 0; v < n; v++) begin
            d = 8'(v & ((1 << nin) - 1));
            s = 3'(v >> nin);
            g = d[s];
            if (mux_eval(f, k, d, s) != g) begin
                r.cnt = r.cnt + 1;
                if (!r.vld) begin
                    r.vld  = 1'b1;
                    r.fvec = 32'(v);
                end
                r.mask = r.mask & (32'(1) << s);
                if (g) s0 = 1'b1;
                else   s1 = 1'b1;
            end
        end
        if (r.cnt == 0)                                 r.cls = 2'b00;
        else if ($countones(r.mask) == 1 && s0 && !s1) r.cls = 2'b01;
        else if ($countones(r.mask) == 1 && s1 && !s0) r.cls = 2'b10;
        else                                            r.cls = 2'b11;
        return r;
    endfunction

    // Run-level reference: start/abort/completion timing in whole vectors
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i] <= IDLE_M;
                m_j[i]   <= 0;
                m_ns[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_run[i] == RUN_M) begin
                    if (ab[i]) begin
                        m_run[i] <= IDLE_M;
                        m_ns[i]  <= m_j[i] / (stl[i] + 1);
                    end else begin
                        m_j[i] <= m_j[i] + 1;
                        if (m_j[i] + 1 == (1 << (sw[i] + (1 << sw[i]))) * (stl[i] + 1)) begin
                            m_run[i] <= DONE_M;
                            m_ns[i]  <= 1 << (sw[i] + (1 << sw[i]));
                        end
                    end
                end else if (st[i]) begin
                    m_run[i] <= RUN_M;
                    m_j[i]   <= 0;
                    m_ns[i]  <= 0;
                    m_f[i]   <= flt[i];
                    m_k[i]   <= fk[i];
                end
            end
        end
    end

    // Every-cycle compare of both instances against the reference
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                sum_t e;
                int   n;
                n = (m_run[i] == RUN_M) ? m_j[i] / (stl[i] + 1) : m_ns[i];
                e = summarize(sw[i], m_f[i], m_k[i], n);
                check("busy", i, 32'(o_busy[i]), 32'(m_run[i] == RUN_M));
                check("done", i, 32'(o_done[i]), 32'(m_run[i] == DONE_M));
                if (m_run[i] == RUN_M)
                    check("vector", i, o_vec[i], 32'(m_j[i] / (stl[i] + 1)));
                check("fail_count", i, o_fc[i], e.cnt);
                check("first_fail_vld", i, 32'(o_vld[i]), 32'(e.vld));
                check("first_fail_vec", i, o_fv[i], e.fvec);
                check("suspect_mask", i, o_mask[i], e.mask);
                check("fault_class", i, 32'(o_cls[i]), (m_run[i] == DONE_M) ? 32'(e.cls) : 32'd0);
            end
        end
    end

    task automatic pulse_start(input int i);
        @(posedge clk);
        #2 st[i] = 1'b1;
        @(posedge clk);
        #2 st[i] = 1'b0;
    endtask

    // Counts edges after the accept edge until done; optionally re-pulses start mid-run
    task automatic wait_done(input int i, input int maxc, input int pulse_at, output int cyc);
        cyc = 0;
        while (!o_done[i] && cyc < maxc) begin
            @(posedge clk);
            #2;
            cyc++;
            st[i] = (cyc == pulse_at);
        end
        st[i] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int cyc;
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", 0, 32'(o_busy[0]), 32'd0);
        check("rst_fc", 1, o_fc[1], 32'd0);
        check("rst_mask", 0, o_mask[0], 32'h3);
        check("rst_mask", 1, o_mask[1], 32'hf);
        check("rst_cls", 0, 32'(o_cls[0]), 32'd0);
        chk_en = 1'b1;
        rst = 1'b0;

        // healthy SEL_W=1 run with a stray start while busy
        flt[0] = F_NONE;
        pulse_start(0);
        wait_done(0, 100, 5, cyc);
        check("len_healthy", 0, 32'(cyc), 32'd16);
        check("healthy_fc", 0, o_fc[0], 32'd0);
        check("healthy_mask", 0, o_mask[0], 32'h3);
        check("healthy_cls", 0, 32'(o_cls[0]), 32'd0);

        // I1 stuck-at-0
        flt[0] = F_SA0; fk[0] = 1;
        pulse_start(0);
        wait_done(0, 100, 0, cyc);
        check("len_sa0", 0, 32'(cyc), 32'd16);
        check("sa0_fc", 0, o_fc[0], 32'd2);
        check("sa0_fvec", 0, o_fv[0], 32'b110);
        check("sa0_mask", 0, o_mask[0], 32'b10);
        check("sa0_cls", 0, 32'(o_cls[0]), 32'd1);

        // select stuck-at-0
        flt[0] = F_SEL0;
        pulse_start(0);
        wait_done(0, 100, 0, cyc);
        check("sel_fc", 0, o_fc[0], 32'd2);
        check("sel_fvec", 0, o_fv[0], 32'b101);
        check("sel_cls", 0, 32'(o_cls[0]), 32'd3);

        // SEL_W=2, SETTLE=2, I2 stuck-at-1
        flt[1] = F_SA1; fk[1] = 2;
        pulse_start(1);
        wait_done(1, 400, 0, cyc);
        check("len_b", 1, 32'(cyc), 32'd192);
        check("b_fc", 1, o_fc[1], 32'd8);
        check("b_fvec", 1, o_fv[1], 32'b100000);
        check("b_mask", 1, o_mask[1], 32'b0100);
        check("b_cls", 1, 32'(o_cls[1]), 32'd2);

        // start from DONE clears results; then async reset during vector 5
        flt[0] = F_SA1; fk[0] = 1;
        pulse_start(0);
        check("restart_busy", 0, 32'(o_busy[0]), 32'd1);
        check("restart_fc", 0, o_fc[0], 32'd0);
        check("restart_cls", 0, 32'(o_cls[0]), 32'd0);
        repeat (11) @(posedge clk);
        #2;
        check("pre_rst_fc", 0, o_fc[0], 32'd1);
        rst = 1'b1;
        #1;
        check("arst_busy", 0, 32'(o_busy[0]), 32'd0);
        check("arst_fc", 0, o_fc[0], 32'd0);
        check("arst_vld", 0, 32'(o_vld[0]), 32'd0);
        check("arst_mask", 0, o_mask[0], 32'h3);
        check("arst_vec", 0, o_vec[0], 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // abort on the SAMPLE cycle of vector 5: vector 5 is not counted
        pulse_start(0);
        repeat (11) @(posedge clk);
        #2 ab[0] = 1'b1;
        @(posedge clk);
        #2 ab[0] = 1'b0;
        check("abort_busy", 0, 32'(o_busy[0]), 32'd0);
        check("abort_done", 0, 32'(o_done[0]), 32'd0);
        check("abort_fc", 0, o_fc[0], 32'd1);
        check("abort_fvec", 0, o_fv[0], 32'b100);

        // clean pass after abort
        flt[0] = F_NONE;
        pulse_start(0);
        wait_done(0, 100, 0, cyc);
        check("len_clean", 0, 32'(cyc), 32'd16);
        check("clean_fc", 0, o_fc[0], 32'd0);
        check("clean_cls", 0, 32'(o_cls[0]), 32'd0);

        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
